// File: rtl/osd_ram_scheduler.sv
// osd_ram_scheduler: arbitrates I2C OSD writes, bulk clears and a deferred-write FIFO onto one RAM write port
module osd_ram_scheduler #(
    parameter int CLEAR_LAST = 1023,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i2c_wren,
    input  logic [9:0] i2c_wraddress,
    input  logic [7:0] i2c_data,
    input  logic       clear_req,
    input  logic [7:0] fill_char,
    output logic       ram_wren,
    output logic [9:0] ram_wraddress,
    output logic [7:0] ram_dataIn,
    output logic       busy,
    output logic       clear_done,
    output logic [7:0] overflow_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

    state_t         state;
    logic           rst_q;
    logic [9:0]     ptr;
    logic [7:0]     fill_q;
    logic [7:0]     fill_next;
    logic           pending;
    logic [17:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  rd;
    logic [AW-1:0]  wr;
    logic [AW:0]    count;
    logic           full;
    logic           pop;
    logic           push_ok;
    logic           drop;
    logic [17:0]    head;

    // reset asserts immediately, releases one edge later so the second edge after release is the first live one
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rst_q <= 1'b0;
        else          rst_q <= 1'b1;

    // FIFO handshakes: pops only while draining, pushes whenever a clear or drain owns the RAM port
    always_comb begin
        full    = count == (AW+1)'(FIFO_DEPTH);
        pop     = state == DRAIN && count != '0;
        push_ok = i2c_wren && state != IDLE && (!full || pop);
        drop    = i2c_wren && state != IDLE && full && !pop;
        head    = mem[rd];
    end

    assign busy = state != IDLE || pending;

    // deferred-write storage; a full FIFO may be written into the slot being popped this cycle
    always_ff @(posedge clk)
        if (push_ok) mem[wr] <= {i2c_wraddress, i2c_data};

    // scheduler FSM with registered RAM port, FIFO pointers and overflow counter
    always_ff @(posedge clk or negedge rst_q) begin
        if (!rst_q) begin
            state          <= IDLE;
            ptr            <= '0;
            fill_q         <= '0;
            fill_next      <= '0;
            pending        <= 1'b0;
            rd             <= '0;
            wr             <= '0;
            count          <= '0;
            ram_wren       <= 1'b0;
            ram_wraddress  <= '0;
            ram_dataIn     <= '0;
            clear_done     <= 1'b0;
            overflow_count <= '0;
        end else begin
            ram_wren   <= 1'b0;
            clear_done <= 1'b0;
            if (push_ok) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (drop && overflow_count != 8'hff) overflow_count <= overflow_count + 1'b1;
            case (state)
                IDLE: begin
                    if (i2c_wren) begin
                        ram_wren      <= 1'b1;
                        ram_wraddress <= i2c_wraddress;
                        ram_dataIn    <= i2c_data;
                    end
                    if (clear_req) begin
                        fill_q <= fill_char;
                        ptr    <= '0;
                        state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    ram_wren      <= 1'b1;
                    ram_wraddress <= ptr;
                    ram_dataIn    <= fill_q;
                    if (ptr == 10'(CLEAR_LAST)) begin
                        clear_done <= 1'b1;
                        state      <= DRAIN;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                    if (clear_req) begin
                        pending   <= 1'b1;
                        fill_next <= fill_char;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        ram_wren                    <= 1'b1;
                        {ram_wraddress, ram_dataIn} <= head;
                    end
                    if (clear_req) begin
                        pending   <= 1'b1;
                        fill_next <= fill_char;
                    end
                    if (!pop && !i2c_wren) begin
                        if (pending || clear_req) begin
                            state   <= CLEAR;
                            ptr     <= '0;
                            pending <= 1'b0;
                            fill_q  <= clear_req ? fill_char : fill_next;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_osd_ram_scheduler.sv
// tb_osd_ram_scheduler: directed self-checking bench for osd_ram_scheduler
module tb_osd_ram_scheduler;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i2c_wren = 1'b0;
    logic [9:0] i2c_wraddress = '0;
    logic [7:0] i2c_data = '0;
    logic       clear_req = 1'b0;
    logic [7:0] fill_char = '0;
    logic       ram_wren;
    logic [9:0] ram_wraddress;
    logic [7:0] ram_dataIn;
    logic       busy;
    logic       clear_done;
    logic [7:0] overflow_count;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] wlog [$];
    logic [7:0]  ram [1024];
    int          cd_cnt = 0;
    int          cd_bad = 0;

    osd_ram_scheduler #(.CLEAR_LAST(1023), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .i2c_wren(i2c_wren), .i2c_wraddress(i2c_wraddress),
        .i2c_data(i2c_data), .clear_req(clear_req), .fill_char(fill_char), .ram_wren(ram_wren),
        .ram_wraddress(ram_wraddress), .ram_dataIn(ram_dataIn), .busy(busy),
        .clear_done(clear_done), .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    // record every RAM write and every clear_done pulse
    always @(negedge clk) begin
        if (ram_wren) begin
            wlog.push_back({ram_wraddress, ram_dataIn});
            ram[ram_wraddress] = ram_dataIn;
        end
        if (clear_done) begin
            cd_cnt++;
            if (!(ram_wren && ram_wraddress == 10'd1023)) cd_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        i2c_wren = 1'b1;
        i2c_wraddress = a;
        i2c_data = d;
        @(negedge clk);
        i2c_wren = 1'b0;
    endtask

    task automatic clr(input logic [7:0] f);
        clear_req = 1'b1;
        fill_char = f;
        @(negedge clk);
        clear_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 4000);
        chk(tag, busy, 0);
        @(negedge clk);
    endtask

    // count log entries from 'first' that are not a clear of fill value f over 0..1023
    function automatic int clear_bad(input int first, input logic [7:0] f);
        int bad = 0;
        for (int i = 0; i < 1024; i++)
            if (first + i >= wlog.size() || wlog[first + i] !== {10'(i), f}) bad++;
        return bad;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_wren", ram_wren, 0);
        chk("rst_addr", ram_wraddress, 0);
        chk("rst_data", ram_dataIn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", clear_done, 0);
        chk("rst_ovf", overflow_count, 0);

        // idle forwarding on the second edge after release
        reset_n = 1'b1;
        @(negedge clk);
        wr(10'h085, 8'h41);
        chk("idle_wren", ram_wren, 1);
        chk("idle_addr", ram_wraddress, 10'h085);
        chk("idle_data", ram_dataIn, 8'h41);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        chk("hold_wren", ram_wren, 0);
        chk("hold_addr", ram_wraddress, 10'h085);
        chk("hold_data", ram_dataIn, 8'h41);

        // clear with six deferred writes, two of which overflow
        wlog.delete();
        cd_cnt = 0;
        clr(8'h20);
        chk("clr_busy", busy, 1);
        wr(10'h010, 8'hAA);
        wr(10'h3FF, 8'hBB);
        wr(10'h010, 8'hCC);
        wr(10'h100, 8'h11);
        wr(10'h101, 8'h22);
        wr(10'h102, 8'h33);
        wait_idle("clr1_idle");
        chk("clr1_len", wlog.size(), 1028);
        chk("clr1_bad", clear_bad(0, 8'h20), 0);
        chk("drain0", wlog.size() > 1024 ? wlog[1024] : 18'h0, {10'h010, 8'hAA});
        chk("drain1", wlog.size() > 1025 ? wlog[1025] : 18'h0, {10'h3FF, 8'hBB});
        chk("drain2", wlog.size() > 1026 ? wlog[1026] : 18'h0, {10'h010, 8'hCC});
        chk("drain3", wlog.size() > 1027 ? wlog[1027] : 18'h0, {10'h100, 8'h11});
        chk("ram_010", ram[10'h010], 8'hCC);
        chk("ram_3ff", ram[10'h3FF], 8'hBB);
        chk("ram_101", ram[10'h101], 8'h20);
        chk("ram_102", ram[10'h102], 8'h20);
        chk("clr1_done_cnt", cd_cnt, 1);
        chk("clr1_done_pos", cd_bad, 0);
        chk("ovf2", overflow_count, 2);

        // saturate the overflow counter: 4 fill the FIFO, 260 more are dropped
        clr(8'h20);
        for (int i = 0; i < 264; i++) wr(10'(i), 8'(i));
        wait_idle("sat_idle");
        chk("ovf_sat", overflow_count, 255);

        // pending clear raised mid-clear, overridden during drain
        wlog.delete();
        cd_cnt = 0;
        cd_bad = 0;
        clr(8'h55);
        wr(10'h200, 8'h01);
        wr(10'h201, 8'h02);
        for (int n = 0; n < 2000 && wlog.size() < 501; n++) @(negedge clk);
        clr(8'h20);
        for (int n = 0; n < 2000 && !clear_done; n++) @(negedge clk);
        chk("c2_done_seen", clear_done, 1);
        clr(8'h00);
        wait_idle("c2_idle");
        chk("c2_len", wlog.size(), 2050);
        chk("c2_first_bad", clear_bad(0, 8'h55), 0);
        chk("c2_drain0", wlog.size() > 1024 ? wlog[1024] : 18'h0, {10'h200, 8'h01});
        chk("c2_drain1", wlog.size() > 1025 ? wlog[1025] : 18'h0, {10'h201, 8'h02});
        chk("c2_second_bad", clear_bad(1026, 8'h00), 0);
        chk("c2_done_cnt", cd_cnt, 2);
        chk("c2_done_pos", cd_bad, 0);

        // reset mid-clear with two queued writes abandons everything
        clr(8'h20);
        wr(10'h300, 8'h01);
        wr(10'h301, 8'h02);
        for (int n = 0; n < 2000 && wlog.size() < 2050 + 301; n++) @(negedge clk);
        chk("r_mid_clear", ram_wren, 1);
        reset_n = 1'b0;
        #1;
        chk("r_wren", ram_wren, 0);
        chk("r_addr", ram_wraddress, 0);
        chk("r_data", ram_dataIn, 0);
        chk("r_busy", busy, 0);
        chk("r_done", clear_done, 0);
        chk("r_ovf", overflow_count, 0);
        repeat (2) @(negedge clk);
        wlog.delete();
        reset_n = 1'b1;
        wr(10'h3AA, 8'h77);
        repeat (1100) @(negedge clk);
        chk("r_no_writes", wlog.size(), 0);
        chk("r_idle", busy, 0);
        wr(10'h123, 8'h5A);
        chk("r_fwd_wren", ram_wren, 1);
        chk("r_fwd_addr", ram_wraddress, 10'h123);
        chk("r_fwd_data", ram_dataIn, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
